stepdown_hiccup_ctrl: RTL and testbench
=======================================

// Module: stepdown_hiccup_ctrl
// PURPOSE
//  Fault-response stage downstream of the stepdown fault block: consumes fault_short and
//  ilimit_fault, gates the stepdown enable and runs hiccup retry (off-time, soft-start blank,
//  retry count, latch-off). Drives the power-stage enable; reports status to the digital core.
// PARAMETERS
//  SS_CYCLES    256  soft-start blanking length; ilimit ignored while active
//  OFF_CYCLES   1024 hiccup off-time, stepdown disabled
//  ILIM_RUN     8    consecutive ilimit cycles in RUN that trigger hiccup
//  GOOD_CYCLES  4096 continuous RUN cycles that clear retry_cnt
//  MAX_RETRY    7    hiccups before latch-off; 0 = retry forever
//  CNT_W        13   timer width; all cycle params must be <= 2^CNT_W-1
//  RTY_W        3    retry_cnt width; MAX_RETRY <= 2^RTY_W-1
// PORTS
//  clk           in   1      core clock
//  PORB97836     in   1      async active-low reset (POR)
//  enable_req    in   1      converter enable request (synchronous)
//  ok_fault      in   1      fault block supply-ok; 0 = abort to IDLE
//  fault_short   in   1      short detect from fault block (async, synchronised here)
//  ilimit_fault  in   1      current-limit flag (async, synchronised here)
//  tmi           in   5      test-mode bus
//  stepdown_en   out  1      power-stage enable
//  ss_active     out  1      high in SOFTSTART
//  hiccup        out  1      high in HICCUP
//  fault_latched out  1      high in LATCH
//  retry_cnt     out  RTY_W  hiccups since last clear
// BEHAVIOUR
//  - Reset (PORB97836=0, async): state IDLE, all timers/counters 0, all outputs 0, syncs 0.
//  - fault_short, ilimit_fault: 2-flop synchronisers; fs_s/il_s lag the input by 2 clk.
//  - Outputs are registered, decoded from state: stepdown_en=1 in SOFTSTART,RUN only.
//  - Global abort: enable_req=0 or ok_fault=0 -> IDLE next cycle from any state; timers and
//    retry_cnt cleared; overrides every transition below.
//  - IDLE: enable_req&ok_fault -> SOFTSTART, timer=0.
//  - SOFTSTART: timer++; il_s ignored; fs_s=1 -> HICCUP; timer==SS_CYCLES-1 -> RUN.
//  - RUN: ilim_cnt++ while il_s=1, cleared when il_s=0; fs_s=1 or ilim_cnt==ILIM_RUN-1
//    with il_s=1 -> HICCUP. good_cnt++ each cycle; reaching GOOD_CYCLES-1 clears retry_cnt
//    (saturates, no repeat action).
//  - Entry to HICCUP: retry_cnt += 1 exactly once even if fs_s and ilimit trigger together.
//    If MAX_RETRY!=0 and new retry_cnt==MAX_RETRY -> LATCH instead of HICCUP.
//  - HICCUP: timer++; fs_s/il_s ignored; timer==OFF_CYCLES-1 -> SOFTSTART, timer=0.
//  - LATCH: stepdown_en=0, fault_latched=1; exit only via global abort.
//  - retry_cnt saturates at 2^RTY_W-1 when MAX_RETRY=0.
//  - Latency: fault_short rise -> stepdown_en fall = 3 clk (2 sync + 1 state).
//  - Timers reset to 0 on every state change; no wrap-around in any state.
// CONFIGURATION
//  STEPDOWN_HICCUP_TMSKIP_EN defined: tmi==5'h1A replaces SS_CYCLES and OFF_CYCLES by 4
//  (ILIM_RUN, GOOD_CYCLES unchanged); tmi change takes effect on next state entry.
//  Undefined: tmi unused, nominal timings always.
// TESTING
//  1 reset, enable_req=1 -> stepdown_en=1 after 1 clk, ss_active 256 clk, then RUN.
//  2 RUN, fault_short pulse 1 clk -> stepdown_en=0 at +3 clk, hiccup 1024 clk,
//    retry_cnt=1, back to SOFTSTART.
//  3 ilimit high 7 clk in RUN -> no hiccup; 8 clk -> hiccup; ilimit in SOFTSTART ignored.
//  4 7 consecutive shorts -> fault_latched=1, stepdown_en stays 0; enable_req=0 -> IDLE,
//    retry_cnt=0.
//  5 retry_cnt=3 then 4096 RUN clk -> retry_cnt=0; PORB97836 low mid-HICCUP -> all outputs 0
//    immediately.
//  6 TMSKIP_EN defined, tmi=5'h1A -> soft-start and off-time 4 clk; tmi=0 -> nominal.

Source files
------------

// File: rtl/stepdown_hiccup_ctrl.sv
// stepdown_hiccup_ctrl: hiccup-mode fault response for the stepdown converter.
// Synchronises the short and current-limit flags, sequences soft-start, run,
// hiccup off-time and latch-off, and drives registered enable/status outputs.
// Optional build macro STEPDOWN_HICCUP_TMSKIP_EN: tmi==5'h1A shortens soft-start
// and off-time to 4 cycles, sampled whenever a new state is entered.
module stepdown_hiccup_ctrl #(
  parameter int SS_CYCLES   = 256,
  parameter int OFF_CYCLES  = 1024,
  parameter int ILIM_RUN    = 8,
  parameter int GOOD_CYCLES = 4096,
  parameter int MAX_RETRY   = 7,
  parameter int CNT_W       = 13,
  parameter int RTY_W       = 3
) (
  input  logic             clk,
  input  logic             PORB97836,
  input  logic             enable_req,
  input  logic             ok_fault,
  input  logic             fault_short,
  input  logic             ilimit_fault,
  input  logic [4:0]       tmi,
  output logic             stepdown_en,
  output logic             ss_active,
  output logic             hiccup,
  output logic             fault_latched,
  output logic [RTY_W-1:0] retry_cnt
);

  typedef enum logic [2:0] {IDLE, SOFTSTART, RUN, HICCUP, LATCH} state_t;

  localparam logic [CNT_W-1:0] SS_LAST   = CNT_W'(SS_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ILIM_LAST = CNT_W'(ILIM_RUN - 1);
  localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(GOOD_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_SAT   = {RTY_W{1'b1}};
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic             LATCH_ON  = (MAX_RETRY != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] ilimCnt_q, ilimCnt_d;
  logic [CNT_W-1:0] goodCnt_q, goodCnt_d;
  logic [RTY_W-1:0] retryCnt_q, retryCnt_d;
  logic [RTY_W-1:0] retryNext;
  logic             tripFault;
  logic             fsMeta_q, fsSync_q, ilMeta_q, ilSync_q;
  logic [CNT_W-1:0] ssLast, offLast;

`ifdef STEPDOWN_HICCUP_TMSKIP_EN
  localparam logic [CNT_W-1:0] TM_LAST = CNT_W'(3);
  logic tmSkip_q;

  // Capture the test-mode shortcut on state entry so a timed phase keeps one length
  always_ff @(posedge clk or negedge PORB97836) begin
    if (!PORB97836) begin
      tmSkip_q <= 1'b0;
    end else if (state_d != state_q) begin
      tmSkip_q <= (tmi == 5'h1A);
    end
  end

  assign ssLast  = tmSkip_q ? TM_LAST : SS_LAST;
  assign offLast = tmSkip_q ? TM_LAST : OFF_LAST;
`else
  logic unusedTmi;
  assign unusedTmi = ^tmi;
  assign ssLast    = SS_LAST;
  assign offLast   = OFF_LAST;
`endif

  // Two-flop synchronisers for the asynchronous fault flags
  always_ff @(posedge clk or negedge PORB97836) begin
    if (!PORB97836) begin
      fsMeta_q <= 1'b0;
      fsSync_q <= 1'b0;
      ilMeta_q <= 1'b0;
      ilSync_q <= 1'b0;
    end else begin
      fsMeta_q <= fault_short;
      fsSync_q <= fsMeta_q;
      ilMeta_q <= ilimit_fault;
      ilSync_q <= ilMeta_q;
    end
  end

  // Next-state, timer and retry bookkeeping; global abort has the final word
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ilimCnt_d  = ilimCnt_q;
    goodCnt_d  = goodCnt_q;
    retryCnt_d = retryCnt_q;
    tripFault  = 1'b0;
    retryNext  = (retryCnt_q == RTY_SAT) ? retryCnt_q : retryCnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (enable_req && ok_fault) state_d = SOFTSTART;
      end
      SOFTSTART: begin
        if (fsSync_q)              tripFault = 1'b1;
        else if (timer_q == ssLast) state_d  = RUN;
        else                        timer_d  = timer_q + 1'b1;
      end
      RUN: begin
        if (fsSync_q || (ilSync_q && (ilimCnt_q == ILIM_LAST))) begin
          tripFault = 1'b1;
        end else begin
          ilimCnt_d = ilSync_q ? ilimCnt_q + 1'b1 : '0;
          if (goodCnt_q == GOOD_LAST) retryCnt_d = '0;
          else                        goodCnt_d  = goodCnt_q + 1'b1;
        end
      end
      HICCUP: begin
        if (timer_q == offLast) state_d = SOFTSTART;
        else                    timer_d = timer_q + 1'b1;
      end
      LATCH: begin
        state_d = LATCH;
      end
      default: state_d = IDLE;
    endcase
    if (tripFault) begin
      retryCnt_d = retryNext;
      state_d    = (LATCH_ON && (retryNext == RTY_LIMIT)) ? LATCH : HICCUP;
    end
    if (state_d != state_q) begin
      timer_d   = '0;
      ilimCnt_d = '0;
      goodCnt_d = '0;
    end
    if (!enable_req || !ok_fault) begin
      state_d    = IDLE;
      timer_d    = '0;
      ilimCnt_d  = '0;
      goodCnt_d  = '0;
      retryCnt_d = '0;
    end
  end

  // State register with outputs decoded from the next state so they change with it
  always_ff @(posedge clk or negedge PORB97836) begin
    if (!PORB97836) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      ilimCnt_q     <= '0;
      goodCnt_q     <= '0;
      retryCnt_q    <= '0;
      stepdown_en   <= 1'b0;
      ss_active     <= 1'b0;
      hiccup        <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ilimCnt_q     <= ilimCnt_d;
      goodCnt_q     <= goodCnt_d;
      retryCnt_q    <= retryCnt_d;
      stepdown_en   <= (state_d == SOFTSTART) || (state_d == RUN);
      ss_active     <= (state_d == SOFTSTART);
      hiccup        <= (state_d == HICCUP);
      fault_latched <= (state_d == LATCH);
    end
  end

  assign retry_cnt = retryCnt_q;

endmodule

// File: tb/tb_stepdown_hiccup_ctrl.sv
// tb_stepdown_hiccup_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a phase/elapsed-time reference model and a set of literal expectations.
module tb_stepdown_hiccup_ctrl;

  localparam int SS_CYCLES   = 256;
  localparam int OFF_CYCLES  = 1024;
  localparam int ILIM_RUN    = 8;
  localparam int GOOD_CYCLES = 4096;
  localparam int MAX_RETRY   = 7;
  localparam int RTY_SAT     = 7;
  localparam int RANDOM_BUDGET = 40000;

  logic       clk          = 1'b0;
  logic       PORB97836    = 1'b0;
  logic       enable_req   = 1'b0;
  logic       ok_fault     = 1'b0;
  logic       fault_short  = 1'b0;
  logic       ilimit_fault = 1'b0;
  logic [4:0] tmi          = 5'h00;
  logic       stepdown_en, ss_active, hiccup, fault_latched;
  logic [2:0] retry_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cycleCount  = 0;

  stepdown_hiccup_ctrl dut (
    .clk          (clk),
    .PORB97836    (PORB97836),
    .enable_req   (enable_req),
    .ok_fault     (ok_fault),
    .fault_short  (fault_short),
    .ilimit_fault (ilimit_fault),
    .tmi          (tmi),
    .stepdown_en  (stepdown_en),
    .ss_active    (ss_active),
    .hiccup       (hiccup),
    .fault_latched(fault_latched),
    .retry_cnt    (retry_cnt)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  typedef enum {PH_OFF, PH_SOFT, PH_RUN, PH_REST, PH_LOCK} phase_e;
  phase_e mPhase   = PH_OFF;
  int     mElapsed = 0;
  int     mIlimRun = 0;
  int     mRetry   = 0;
  bit     fsHist[2];
  bit     ilHist[2];
  bit     fsNow, ilNow;

  function automatic void goTo(input phase_e p);
    mPhase   = p;
    mElapsed = 0;
    mIlimRun = 0;
  endfunction

  function automatic void tripFault();
    mRetry = (mRetry < RTY_SAT) ? mRetry + 1 : RTY_SAT;
    if (MAX_RETRY != 0 && mRetry == MAX_RETRY) goTo(PH_LOCK);
    else                                       goTo(PH_REST);
  endfunction

  // Reference model: phase plus cycles elapsed in it, flags seen two edges late
  always @(posedge clk or negedge PORB97836) begin
    if (!PORB97836) begin
      goTo(PH_OFF);
      mRetry = 0;
      fsHist[0] = 1'b0; fsHist[1] = 1'b0;
      ilHist[0] = 1'b0; ilHist[1] = 1'b0;
    end else begin
      fsNow = fsHist[1];
      ilNow = ilHist[1];
      fsHist[1] = fsHist[0]; fsHist[0] = fault_short;
      ilHist[1] = ilHist[0]; ilHist[0] = ilimit_fault;
      if (!enable_req || !ok_fault) begin
        goTo(PH_OFF);
        mRetry = 0;
      end else begin
        mElapsed++;
        case (mPhase)
          PH_OFF:  goTo(PH_SOFT);
          PH_SOFT: begin
            if (fsNow)                       tripFault();
            else if (mElapsed == SS_CYCLES)  goTo(PH_RUN);
          end
          PH_RUN: begin
            mIlimRun = ilNow ? mIlimRun + 1 : 0;
            if (fsNow || mIlimRun == ILIM_RUN) tripFault();
            else if (mElapsed >= GOOD_CYCLES)  mRetry = 0;
          end
          PH_REST: begin
            if (mElapsed == OFF_CYCLES) goTo(PH_SOFT);
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [6:0] got, want;
    got  = {stepdown_en, ss_active, hiccup, fault_latched, retry_cnt};
    want = {(mPhase == PH_SOFT) || (mPhase == PH_RUN), mPhase == PH_SOFT,
            mPhase == PH_REST, mPhase == PH_LOCK, 3'(mRetry)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      if (miscompares <= 30)
        $display("[TB] FAIL model_cycle t=%0t en/ss/hic/lat/rty dut=%b model=%b", $time, got, want);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got=%0d expected=%0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ok, input logic fs,
                               input logic il, input int cycles);
    enable_req   = en;
    ok_fault     = ok;
    fault_short  = fs;
    ilimit_fault = il;
    repeat (cycles) @(negedge clk);
    cycleCount += cycles;
  endtask

  initial begin
    int pick;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("por_en", stepdown_en, 0);
    checkOutput("por_ss", ss_active, 0);
    checkOutput("por_hiccup", hiccup, 0);
    checkOutput("por_latched", fault_latched, 0);
    checkOutput("por_retry", retry_cnt, 0);
    PORB97836 = 1'b1;
    applyStimulus(0, 1, 0, 0, 2);

    // Start-up: enable one clock later, 256 cycles of soft-start, then run
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("start_en", stepdown_en, 1);
    checkOutput("start_ss", ss_active, 1);
    applyStimulus(1, 1, 0, 0, 255);
    checkOutput("ss_last_cycle", ss_active, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("run_ss_off", ss_active, 0);
    checkOutput("run_en", stepdown_en, 1);

    // Short pulse: enable drops on the third clock, 1024-cycle off-time
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("short_en_plus2", stepdown_en, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("short_en_plus3", stepdown_en, 0);
    checkOutput("short_hiccup", hiccup, 1);
    checkOutput("short_retry", retry_cnt, 1);
    applyStimulus(1, 1, 0, 0, 1023);
    checkOutput("off_last_cycle", hiccup, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("off_done_hiccup", hiccup, 0);
    checkOutput("off_done_ss", ss_active, 1);
    applyStimulus(1, 1, 0, 0, 256);
    checkOutput("rerun_ss", ss_active, 0);
    checkOutput("rerun_en", stepdown_en, 1);

    // Current limit: 7 cycles tolerated, 8 trips; ignored during soft-start
    applyStimulus(1, 1, 0, 1, 7);
    applyStimulus(1, 1, 0, 0, 4);
    checkOutput("ilim7_hiccup", hiccup, 0);
    checkOutput("ilim7_retry", retry_cnt, 1);
    applyStimulus(1, 1, 0, 1, 8);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("ilim8_before", hiccup, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("ilim8_hiccup", hiccup, 1);
    checkOutput("ilim8_retry", retry_cnt, 2);
    applyStimulus(1, 1, 0, 0, 1024);
    checkOutput("ss_after_ilim", ss_active, 1);
    applyStimulus(1, 1, 0, 1, 100);
    checkOutput("ss_ilim_ignored", ss_active, 1);
    checkOutput("ss_ilim_retry", retry_cnt, 2);
    applyStimulus(1, 1, 0, 0, 156);
    checkOutput("run_after_ss_ilim", stepdown_en, 1);
    checkOutput("run_after_ss_ilim_ss", ss_active, 0);

    // Aborts via enable_req and ok_fault
    applyStimulus(0, 1, 0, 0, 2);
    checkOutput("abort_en", stepdown_en, 0);
    checkOutput("abort_retry", retry_cnt, 0);
    applyStimulus(1, 1, 0, 0, 10);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("okfault_abort_ss", ss_active, 0);
    checkOutput("okfault_abort_en", stepdown_en, 0);

    // Persistent short: seventh hiccup latches off until enable is dropped
    applyStimulus(1, 1, 1, 0, 6200);
    checkOutput("latch_flag", fault_latched, 1);
    checkOutput("latch_en", stepdown_en, 0);
    checkOutput("latch_retry", retry_cnt, 7);
    applyStimulus(1, 1, 0, 0, 2000);
    checkOutput("latch_held", fault_latched, 1);
    checkOutput("latch_held_en", stepdown_en, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("unlatch_flag", fault_latched, 0);
    checkOutput("unlatch_retry", retry_cnt, 0);

    // Three hiccups, then a long clean run clears the retry count
    applyStimulus(1, 1, 1, 0, 2100);
    checkOutput("three_retry", retry_cnt, 3);
    checkOutput("three_hiccup", hiccup, 1);
    applyStimulus(1, 1, 0, 0, 1240);
    checkOutput("good_run_en", stepdown_en, 1);
    checkOutput("good_run_retry", retry_cnt, 3);
    applyStimulus(1, 1, 0, 0, 4060);
    checkOutput("good_not_yet", retry_cnt, 3);
    applyStimulus(1, 1, 0, 0, 40);
    checkOutput("good_cleared", retry_cnt, 0);

    // Power-on reset in the middle of an off-time
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 10);
    checkOutput("pre_por_hiccup", hiccup, 1);
    checkOutput("pre_por_retry", retry_cnt, 1);
    #2 PORB97836 = 1'b0;
    #1;
    checkOutput("por_mid_hiccup", hiccup, 0);
    checkOutput("por_mid_retry", retry_cnt, 0);
    checkOutput("por_mid_en", stepdown_en, 0);
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 3);
    PORB97836 = 1'b1;

    // Randomized traffic checked by the per-cycle model
    while (cycleCount < RANDOM_BUDGET) begin
      pick = int'($urandom_range(0, 99));
      tmi  = 5'($urandom_range(0, 25));
      if (pick < 5) begin
        if ($urandom_range(0, 1) == 1) applyStimulus(0, 1, 0, 0, int'($urandom_range(1, 3)));
        else                            applyStimulus(1, 0, 0, 0, int'($urandom_range(1, 3)));
      end else if (pick < 30) begin
        applyStimulus(1, 1, 1, 0, int'($urandom_range(1, 3)));
      end else if (pick < 60) begin
        applyStimulus(1, 1, 0, 1, int'($urandom_range(ILIM_RUN - 3, ILIM_RUN + 3)));
      end else if (pick < 65) begin
        applyStimulus(1, 1, 0, 0, int'($urandom_range(4000, 5000)));
      end else begin
        applyStimulus(1, 1, 0, 0, int'($urandom_range(1, 700)));
      end
    end

    applyStimulus(1, 1, 0, 0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
